// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: word SRAM with fixed-latency handshake.
// Optional read/write counters enabled by defining LC3B_MEM_STATS_EN.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error
`ifdef LC3B_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept;

  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        wr_q;

  logic [15:0] mem_q [DEPTH];

  logic unused_addr;
  assign unused_addr = &{1'b0, mem_address[15:ADDR_BITS+1],
                         mem_address[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      mem_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && mem_read && mem_write) mem_error <= 1'b1;
    end
  end

  // Transaction latch; a read+write collision is serviced as a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      wr_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= mem_address[ADDR_BITS:1];
      wdata_q <= mem_wdata;
      be_q    <= mem_byte_enable;
      wr_q    <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && state_q == RESP && wr_q) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_rdata = (state_q == RESP && !wr_q) ? mem_q[idx_q]
                                                : 16'h0000;

`ifdef LC3B_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (state_q == RESP) begin
      if (wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
